// File: rtl/pcm_mem_arbiter_if.sv
// CPU-side strobe bus and PCM memory slave bus shared by the four cores
// and the arbiter. The arbiter connects through the slave modport; the
// CPUs and the memory conduit are on the master side.
interface pcm_mem_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int CPU_ADDR_W = 16,
    parameter int MEM_ADDR_W = 11,
    parameter int DATA_W     = 16,
    parameter int ID_W       = 2
);
    // CPU request strobes, all active low
    logic [N_REQ-1:0]            cpu_ce_n;
    logic [N_REQ-1:0]            cpu_oe_n;
    logic [N_REQ-1:0]            cpu_we_n;
    logic [N_REQ-1:0]            cpu_ub_n;
    logic [N_REQ-1:0]            cpu_lb_n;
    logic [N_REQ*CPU_ADDR_W-1:0] cpu_addr;
    logic [N_REQ*DATA_W-1:0]     cpu_wdata;

    // CPU completion side
    logic [DATA_W-1:0]           cpu_rdata;
    logic [N_REQ-1:0]            cpu_ack;
    logic [ID_W-1:0]             grant_id;
    logic                        busy;

    // PCM memory slave port
    logic [MEM_ADDR_W-1:0]       pcm_mem_mm_address;
    logic                        pcm_mem_mm_chipselect;
    logic                        pcm_mem_mm_clken;
    logic                        pcm_mem_mm_write;
    logic [DATA_W-1:0]           pcm_mem_mm_writedata;
    logic [1:0]                  pcm_mem_mm_byteenable;
    logic [DATA_W-1:0]           pcm_mem_mm_readdata;

    modport slave (
        input  cpu_ce_n, cpu_oe_n, cpu_we_n, cpu_ub_n, cpu_lb_n,
        input  cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, grant_id, busy,
        output pcm_mem_mm_address, pcm_mem_mm_chipselect, pcm_mem_mm_clken,
        output pcm_mem_mm_write, pcm_mem_mm_writedata, pcm_mem_mm_byteenable,
        input  pcm_mem_mm_readdata
    );

    modport master (
        output cpu_ce_n, cpu_oe_n, cpu_we_n, cpu_ub_n, cpu_lb_n,
        output cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, grant_id, busy,
        input  pcm_mem_mm_address, pcm_mem_mm_chipselect, pcm_mem_mm_clken,
        input  pcm_mem_mm_write, pcm_mem_mm_writedata, pcm_mem_mm_byteenable,
        output pcm_mem_mm_readdata
    );
endinterface

// File: rtl/pcm_mem_arbiter.sv
// Round-robin arbiter sharing the single PCM on-chip memory port between
// the LC-3 cores. One transaction is in flight at a time:
//   IDLE -> ISSUE -> ACK -> IDLE            (write, ack 2 cycles after sampling)
//   IDLE -> ISSUE -> RDWAIT -> ACK -> IDLE  (read,  ack 3 cycles after sampling)
// Addresses with any bit above the memory word range set are acknowledged
// normally but never reach the memory; such reads return zero.
// The rotation uses natural wrap of the pointer, so N_REQ is a power of two.
module pcm_mem_arbiter #(
    parameter int N_REQ      = 4,
    parameter int CPU_ADDR_W = 16,
    parameter int MEM_ADDR_W = 11,
    parameter int DATA_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    pcm_mem_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t                 state_q, state_d;

    // Control registers
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        grant_id_q;
    logic [DATA_W-1:0]      rdata_q;

    // Transaction latches captured at grant
    logic [MEM_ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [1:0]             be_q;
    logic                   is_write_q;
    logic                   oor_q;

    // Arbitration
    logic [N_REQ-1:0]       req;
    logic                   arb_found;
    logic [ID_W-1:0]        arb_idx;
    logic [ID_W-1:0]        cand;
    logic                   grant_now;

    // Fields of the CPU selected by the arbiter
    logic [CPU_ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   sel_write;
    logic [1:0]             sel_be;
    logic                   sel_oor;

    // Combinational outputs
    logic                   mem_cs;
    logic                   mem_clken;
    logic                   mem_write;
    logic [MEM_ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [1:0]             mem_be;
    logic [N_REQ-1:0]       ack_d;
    logic                   busy_d;

    // A strobe set is a request only when a direction strobe accompanies ce_n;
    // with both we_n and oe_n low the write wins.
    assign req = ~bus.cpu_ce_n & (~bus.cpu_we_n | ~bus.cpu_oe_n);

    // Round-robin search starting at ptr_q; first requester found wins
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr_q + ID_W'(k);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign sel_addr  = bus.cpu_addr[arb_idx*CPU_ADDR_W +: CPU_ADDR_W];
    assign sel_wdata = bus.cpu_wdata[arb_idx*DATA_W +: DATA_W];
    assign sel_write = ~bus.cpu_we_n[arb_idx];
    // Reads always fetch the full word; byte lanes only qualify writes
    assign sel_be    = sel_write ? {~bus.cpu_ub_n[arb_idx], ~bus.cpu_lb_n[arb_idx]}
                                 : 2'b11;
    assign sel_oor   = |sel_addr[CPU_ADDR_W-1:MEM_ADDR_W];

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and all state-decoded outputs
    always_comb begin
        state_d   = state_q;
        grant_now = 1'b0;
        mem_cs    = 1'b0;
        mem_clken = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        ack_d     = '0;
        busy_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (arb_found) begin
                    grant_now = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Out-of-range accesses keep the memory port completely quiet
                if (!oor_q) begin
                    mem_cs    = 1'b1;
                    mem_clken = 1'b1;
                    mem_write = is_write_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                    mem_be    = be_q;
                end
                state_d = is_write_q ? S_ACK : S_RDWAIT;
            end
            S_RDWAIT: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                ack_d[grant_id_q] = 1'b1;
                state_d           = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Transaction latches; only meaningful while a transaction is in flight
    always_ff @(posedge Clk) begin
        if (grant_now) begin
            addr_q     <= sel_addr[MEM_ADDR_W-1:0];
            wdata_q    <= sel_wdata;
            be_q       <= sel_be;
            is_write_q <= sel_write;
            oor_q      <= sel_oor;
        end
    end

    // Pointer rotation, served-CPU index and read-data capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q      <= '0;
            grant_id_q <= '0;
            rdata_q    <= '0;
        end else begin
            if (grant_now) begin
                ptr_q      <= arb_idx + 1'b1;
                grant_id_q <= arb_idx;
            end
            // Memory read latency is one cycle, so data is valid during RDWAIT
            if (state_q == S_RDWAIT) begin
                rdata_q <= oor_q ? '0 : bus.pcm_mem_mm_readdata;
            end
        end
    end

    assign bus.cpu_rdata             = rdata_q;
    assign bus.cpu_ack               = ack_d;
    assign bus.grant_id              = grant_id_q;
    assign bus.busy                  = busy_d;
    assign bus.pcm_mem_mm_address    = mem_addr;
    assign bus.pcm_mem_mm_chipselect = mem_cs;
    assign bus.pcm_mem_mm_clken      = mem_clken;
    assign bus.pcm_mem_mm_write      = mem_write;
    assign bus.pcm_mem_mm_writedata  = mem_wdata;
    assign bus.pcm_mem_mm_byteenable = mem_be;

endmodule

// File: tb/tb_pcm_mem_arbiter.sv
// Directed bench for pcm_mem_arbiter: a table of single-CPU transactions
// plus hand-written sequences for round-robin, withdrawal and reset.
module tb_pcm_mem_arbiter;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic mem_clear = 1'b1;

    always #5 Clk = ~Clk;

    pcm_mem_arbiter_if bus ();

    pcm_mem_arbiter dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // PCM memory model: 2048 x 16, byte-enabled writes, 1-cycle read latency
    logic [15:0] mem [2048];
    always @(posedge Clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
            bus.pcm_mem_mm_readdata <= 16'h0000;
        end else if (bus.pcm_mem_mm_chipselect && bus.pcm_mem_mm_clken) begin
            if (bus.pcm_mem_mm_write) begin
                if (bus.pcm_mem_mm_byteenable[0])
                    mem[bus.pcm_mem_mm_address][7:0] <= bus.pcm_mem_mm_writedata[7:0];
                if (bus.pcm_mem_mm_byteenable[1])
                    mem[bus.pcm_mem_mm_address][15:8] <= bus.pcm_mem_mm_writedata[15:8];
            end else begin
                bus.pcm_mem_mm_readdata <= mem[bus.pcm_mem_mm_address];
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] exp_hold = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // op: 0 = read, 1 = write, 2 = write with oe_n also low
    typedef struct {
        int          cpu;
        int          op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        ub_n;
        logic        lb_n;
        int          exp_lat;
        logic        exp_cs;
        logic [1:0]  exp_be;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vt [12];

    task automatic release_all();
        bus.cpu_ce_n  = '1;
        bus.cpu_oe_n  = '1;
        bus.cpu_we_n  = '1;
        bus.cpu_ub_n  = '1;
        bus.cpu_lb_n  = '1;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    task automatic drive(input int cpu, input int op, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic ub_n, input logic lb_n);
        bus.cpu_ce_n[cpu] = 1'b0;
        bus.cpu_we_n[cpu] = (op == 0);
        bus.cpu_oe_n[cpu] = (op == 1);
        bus.cpu_ub_n[cpu] = ub_n;
        bus.cpu_lb_n[cpu] = lb_n;
        bus.cpu_addr[cpu*16 +: 16]  = addr;
        bus.cpu_wdata[cpu*16 +: 16] = wdata;
    endtask

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Drive one transaction in an IDLE cycle and check it end to end
    task automatic run_vec(input vec_t v, input string tag);
        logic [3:0]  exp_ack;
        logic [10:0] exp_addr;
        logic        cs_seen;
        int          lat;
        exp_ack = '0;
        exp_ack[v.cpu] = 1'b1;
        exp_addr = v.exp_cs ? v.addr[10:0] : 11'h000;
        cs_seen = 1'b0;
        lat = 0;
        drive(v.cpu, v.op, v.addr, v.wdata, v.ub_n, v.lb_n);
        for (int n = 1; n <= 8; n++) begin
            cyc();
            if (bus.pcm_mem_mm_chipselect) cs_seen = 1'b1;
            if (n == 1) begin
                chk({tag, " issue_busy"}, 32'(bus.busy), 32'd1);
                chk({tag, " issue_addr"}, 32'(bus.pcm_mem_mm_address), 32'(exp_addr));
                chk({tag, " issue_write"}, 32'(bus.pcm_mem_mm_write),
                    32'((v.op != 0) && v.exp_cs));
                chk({tag, " issue_be"}, 32'(bus.pcm_mem_mm_byteenable), 32'(v.exp_be));
            end
            if (bus.cpu_ack != 4'b0000) begin
                lat = n;
                chk({tag, " ack_vec"}, 32'(bus.cpu_ack), 32'(exp_ack));
                chk({tag, " grant_id"}, 32'(bus.grant_id), 32'(v.cpu));
                if (v.op == 0) begin
                    chk({tag, " rdata"}, 32'(bus.cpu_rdata), 32'(v.exp_rdata));
                    exp_hold = v.exp_rdata;
                end
                release_all();
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " cs_seen"}, 32'(cs_seen), 32'(v.exp_cs));
        if (lat == 0) release_all();
        cyc();
        chk({tag, " post_ack"}, 32'(bus.cpu_ack), 32'd0);
        chk({tag, " rdata_hold"}, 32'(bus.cpu_rdata), 32'(exp_hold));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [3:0]  ack;
        int          order [5];
        int          last_cyc;
        int          n_acks;
        int          lat;

        //           cpu op addr      wdata     ub    lb    lat cs    be     rdata
        vt[0]  = '{1, 1, 16'h0005, 16'hBEEF, 1'b0, 1'b0, 2, 1'b1, 2'b11, 16'h0000};
        vt[1]  = '{2, 0, 16'h0005, 16'h0000, 1'b1, 1'b1, 3, 1'b1, 2'b11, 16'hBEEF};
        vt[2]  = '{0, 1, 16'h0010, 16'h5678, 1'b0, 1'b0, 2, 1'b1, 2'b11, 16'h0000};
        vt[3]  = '{0, 1, 16'h0010, 16'h1234, 1'b1, 1'b0, 2, 1'b1, 2'b01, 16'h0000};
        vt[4]  = '{2, 0, 16'h0010, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'h5634};
        vt[5]  = '{3, 0, 16'h0800, 16'h0000, 1'b0, 1'b0, 3, 1'b0, 2'b00, 16'h0000};
        vt[6]  = '{3, 2, 16'hF805, 16'hFFFF, 1'b0, 1'b0, 2, 1'b0, 2'b00, 16'h0000};
        vt[7]  = '{1, 0, 16'h0005, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'hBEEF};
        vt[8]  = '{0, 1, 16'h07FF, 16'hA5C3, 1'b0, 1'b1, 2, 1'b1, 2'b10, 16'h0000};
        vt[9]  = '{1, 0, 16'h07FF, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'hA500};
        vt[10] = '{2, 2, 16'h0000, 16'h0001, 1'b0, 1'b0, 2, 1'b1, 2'b11, 16'h0000};
        vt[11] = '{3, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'h0001};

        release_all();
        Reset = 1'b1;
        mem_clear = 1'b1;
        repeat (3) cyc();
        mem_clear = 1'b0;

        // Reset state
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst ack", 32'(bus.cpu_ack), 32'd0);
        chk("rst grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst cs", 32'(bus.pcm_mem_mm_chipselect), 32'd0);
        chk("rst mem_out", 32'({bus.pcm_mem_mm_clken, bus.pcm_mem_mm_write,
            bus.pcm_mem_mm_address, bus.pcm_mem_mm_byteenable}), 32'd0);
        chk("rst wdata", 32'(bus.pcm_mem_mm_writedata), 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Strobes withdrawn during ISSUE: the write still completes and acks
        drive(2, 1, 16'h0020, 16'h0C0C, 1'b0, 1'b0);
        cyc();
        release_all();
        cyc();
        chk("withdraw ack", 32'(bus.cpu_ack), 32'b0100);
        chk("withdraw busy", 32'(bus.busy), 32'd1);
        cyc();
        chk("withdraw idle", 32'(bus.busy), 32'd0);
        v = '{2, 0, 16'h0020, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'h0C0C};
        run_vec(v, "withdraw_rd");

        // Reset during RDWAIT of a CPU1 read
        drive(1, 0, 16'h0005, 16'h0000, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("rdwait busy", 32'(bus.busy), 32'd1);
        chk("rdwait ack", 32'(bus.cpu_ack), 32'd0);
        Reset = 1'b1;
        cyc();
        chk("midrst ack", 32'(bus.cpu_ack), 32'd0);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst mem_out", 32'({bus.pcm_mem_mm_chipselect, bus.pcm_mem_mm_clken,
            bus.pcm_mem_mm_write, bus.pcm_mem_mm_address, bus.pcm_mem_mm_byteenable}), 32'd0);
        chk("midrst grant_id", 32'(bus.grant_id), 32'd0);
        chk("midrst rdata", 32'(bus.cpu_rdata), 32'd0);
        Reset = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            if (bus.cpu_ack != 4'b0000) begin
                lat = n;
                chk("postrst ack", 32'(bus.cpu_ack), 32'b0010);
                chk("postrst rdata", 32'(bus.cpu_rdata), 32'hBEEF);
                chk("postrst grant_id", 32'(bus.grant_id), 32'd1);
                release_all();
                break;
            end
        end
        chk("postrst latency", 32'(lat), 32'd3);
        release_all();
        cyc();

        // All four CPUs request writes continuously from reset
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 1, 16'(16'h0100 + i), 16'(i), 1'b0, 1'b0);
        cyc();
        Reset = 1'b0;
        n_acks = 0;
        last_cyc = 0;
        for (int c = 1; c <= 40 && n_acks < 5; c++) begin
            cyc();
            ack = bus.cpu_ack;
            if (ack != 4'b0000) begin
                chk("rr onehot", 32'($onehot(ack)), 32'd1);
                order[n_acks] = (ack[1] ? 1 : 0) + (ack[2] ? 2 : 0) + (ack[3] ? 3 : 0);
                chk($sformatf("rr order%0d", n_acks), 32'(order[n_acks]), 32'(n_acks % 4));
                chk($sformatf("rr grant%0d", n_acks), 32'(bus.grant_id), 32'(n_acks % 4));
                if (n_acks > 0) chk($sformatf("rr gap%0d", n_acks), 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                n_acks++;
            end
        end
        chk("rr ack_count", 32'(n_acks), 32'd5);
        release_all();
        cyc();
        cyc();
        chk("rr mem_0102", 32'(mem[11'h102]), 32'h0002);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
